usb_rx_rcu: RTL

USB_RX_RCU -- requirements
Module: usb_rx_rcu

---
 rtl/usb_rx_pkg.sv | 56 +++++
 rtl/usb_rx_rcu.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/usb_rx_pkg.sv
// Shared definitions for the USB receive control unit: FSM states,
// PID byte values, decoded packet codes and the SYNC pattern.
package usb_rx_pkg;

    typedef enum logic [3:0] {
        IDLE,
        SYNC_WAIT,
        SYNC_CHK,
        PID_WAIT,
        PID_CHK,
        TOKEN_WAIT,
        DATA_WAIT,
        STORE,
        EOP_WAIT,
        DONE,
        ERR,
        ERR_IDLE
    } state_t;

    localparam logic [7:0] SYNC_BYTE = 8'h80;

    localparam logic [7:0] PID_OUT   = 8'hE1;
    localparam logic [7:0] PID_IN    = 8'h69;
    localparam logic [7:0] PID_DATA0 = 8'hC3;
    localparam logic [7:0] PID_DATA1 = 8'h4B;
    localparam logic [7:0] PID_ACK   = 8'hD2;
    localparam logic [7:0] PID_NAK   = 8'h5A;

    localparam logic [2:0] PKT_NONE  = 3'd0;
    localparam logic [2:0] PKT_OUT   = 3'd1;
    localparam logic [2:0] PKT_IN    = 3'd2;
    localparam logic [2:0] PKT_DATA0 = 3'd3;
    localparam logic [2:0] PKT_DATA1 = 3'd4;
    localparam logic [2:0] PKT_ACK   = 3'd5;
    localparam logic [2:0] PKT_NAK   = 3'd6;

    // Map a received PID byte to its packet code; PKT_NONE means the byte
    // failed the nibble-complement check or is not a supported PID.
    function automatic logic [2:0] pid_decode(input logic [7:0] pid);
        logic [2:0] code;
        code = PKT_NONE;
        if (pid[7:4] == ~pid[3:0]) begin
            case (pid)
                PID_OUT:   code = PKT_OUT;
                PID_IN:    code = PKT_IN;
                PID_DATA0: code = PKT_DATA0;
                PID_DATA1: code = PKT_DATA1;
                PID_ACK:   code = PKT_ACK;
                PID_NAK:   code = PKT_NAK;
                default:   code = PKT_NONE;
            endcase
        end
        return code;
    endfunction

endpackage

// File: rtl/usb_rx_rcu.sv
// USB receive control unit: tracks SYNC/PID/payload/EOP of an incoming
// packet, strobes payload bytes into the RX FIFO and flags errors.
module usb_rx_rcu
    import usb_rx_pkg::*;
#(
    parameter int MAX_BYTES = 64
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       d_edge,
    input  logic       eop,
    input  logic       shift_enable,
    input  logic       byte_received,
    input  logic [7:0] rcv_data,
    input  logic [6:0] buffer_occupancy,
    output logic       rcving,
    output logic       enable_timer,
    output logic       w_enable,
    output logic       flush,
    output logic       rx_data_ready,
    output logic       rx_error,
    output logic [2:0] rx_packet
);

    state_t     r_state;
    state_t     w_state_next;
    logic [1:0] r_tok_cnt;
    logic [1:0] w_tok_cnt_next;
    logic       r_rcving;
    logic       r_flush;
    logic       r_rdy;
    logic       r_err;
    logic       w_err_next;
    logic       w_flush_next;
    logic [2:0] r_pkt;
    logic [2:0] w_pkt_next;
    logic       w_eop_hit;
    logic       w_room;
    logic [2:0] w_pid_code;

    // An SE0 only counts once the bit timer samples it, and it outranks a
    // byte completing in the same cycle.
    assign w_eop_hit  = eop & shift_enable;
    assign w_room     = ({25'd0, buffer_occupancy} < $unsigned(MAX_BYTES));
    assign w_pid_code = pid_decode(rcv_data);

    // Next-state and next-output logic for the packet-framing FSM.
    always_comb begin
        w_state_next   = r_state;
        w_tok_cnt_next = r_tok_cnt;
        w_err_next     = r_err;
        w_pkt_next     = r_pkt;
        w_flush_next   = 1'b0;
        case (r_state)
            IDLE: begin
                if (d_edge) begin
                    w_state_next = SYNC_WAIT;
                    w_err_next   = 1'b0;
                end
            end
            SYNC_WAIT: begin
                if (w_eop_hit)          w_state_next = ERR;
                else if (byte_received) w_state_next = SYNC_CHK;
            end
            SYNC_CHK: begin
                w_state_next = (rcv_data == SYNC_BYTE) ? PID_WAIT : ERR;
            end
            PID_WAIT: begin
                if (w_eop_hit)          w_state_next = ERR;
                else if (byte_received) w_state_next = PID_CHK;
            end
            PID_CHK: begin
                if (w_pid_code == PKT_NONE) begin
                    w_state_next = ERR;
                end else begin
                    w_pkt_next = w_pid_code;
                    case (w_pid_code)
                        PKT_OUT, PKT_IN: begin
                            w_state_next   = TOKEN_WAIT;
                            w_tok_cnt_next = 2'd0;
                        end
                        PKT_DATA0, PKT_DATA1: begin
                            w_state_next = DATA_WAIT;
                            w_flush_next = 1'b1;
                        end
                        default: w_state_next = EOP_WAIT;
                    endcase
                end
            end
            TOKEN_WAIT: begin
                // Token payload (address/endpoint/CRC5) is two bytes and is
                // deliberately not forwarded to the FIFO.
                if (w_eop_hit) begin
                    w_state_next = ERR;
                end else if (byte_received) begin
                    if (r_tok_cnt == 2'd1) begin
                        w_state_next   = EOP_WAIT;
                        w_tok_cnt_next = 2'd0;
                    end else begin
                        w_tok_cnt_next = r_tok_cnt + 2'd1;
                    end
                end
            end
            DATA_WAIT: begin
                if (w_eop_hit)          w_state_next = DONE;
                else if (byte_received) w_state_next = STORE;
            end
            STORE: begin
                w_state_next = w_room ? DATA_WAIT : ERR;
            end
            EOP_WAIT: begin
                if (w_eop_hit)          w_state_next = DONE;
                else if (byte_received) w_state_next = ERR;
            end
            DONE: begin
                w_state_next = IDLE;
            end
            ERR: begin
                if (w_eop_hit) w_state_next = ERR_IDLE;
            end
            ERR_IDLE: begin
                if (d_edge) begin
                    w_state_next = SYNC_WAIT;
                    w_err_next   = 1'b0;
                end
            end
            default: w_state_next = IDLE;
        endcase
        if (w_state_next == ERR) w_err_next = 1'b1;
    end

    // State register; outputs are registered from the next state so they
    // line up with the state they belong to.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_tok_cnt <= 2'd0;
            r_rcving  <= 1'b0;
            r_flush   <= 1'b0;
            r_rdy     <= 1'b0;
            r_err     <= 1'b0;
            r_pkt     <= PKT_NONE;
        end else begin
            r_state   <= w_state_next;
            r_tok_cnt <= w_tok_cnt_next;
            r_rcving  <= !((w_state_next == IDLE) || (w_state_next == DONE) ||
                           (w_state_next == ERR_IDLE));
            r_flush   <= w_flush_next;
            r_rdy     <= (w_state_next == DONE);
            r_err     <= w_err_next;
            r_pkt     <= w_pkt_next;
        end
    end

    // The write strobe depends on FIFO room sampled during STORE itself.
    assign w_enable      = (r_state == STORE) && w_room;
    assign rcving        = r_rcving;
    assign enable_timer  = r_rcving;
    assign flush         = r_flush;
    assign rx_data_ready = r_rdy;
    assign rx_error      = r_err;
    assign rx_packet     = r_pkt;

endmodule
